// File: rtl/seg_pkg.sv
// Shared seven-segment constants for the display path.
// Segment vectors are active-low in bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;
  typedef logic [6:0] seg_t;

  localparam digit_idx_t IDX_LAST = 2'd3;

  localparam seg_t SEG_0    = 7'h40;
  localparam seg_t SEG_1    = 7'h79;
  localparam seg_t SEG_2    = 7'h24;
  localparam seg_t SEG_3    = 7'h30;
  localparam seg_t SEG_4    = 7'h19;
  localparam seg_t SEG_5    = 7'h12;
  localparam seg_t SEG_6    = 7'h02;
  localparam seg_t SEG_7    = 7'h78;
  localparam seg_t SEG_8    = 7'h00;
  localparam seg_t SEG_9    = 7'h10;
  localparam seg_t SEG_DASH = 7'h3F;
  localparam seg_t SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Non-BCD codes (A-F) show a dash so corrupted counter values are visible.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed 4-digit common-anode display driver: one digit per refresh slot,
// with all inputs snapshotted once per frame so a frame never mixes two counts.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] num,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc;
  digit_idx_t    idx;
  logic [15:0]   snap_num;
  logic [3:0]    snap_dp;
  logic          snap_blz;
  // Holds the outputs dark until the first snapshot has been taken.
  logic          active;

  logic          tick;
  logic [3:0]    cur_digit;
  logic [3:0]    zero;
  logic [3:0]    blank;
  seg_t          dec_seg;

  assign tick      = (presc == PRESC_LAST);
  assign cur_digit = snap_num[{idx, 2'b00} +: 4];

  assign zero[0] = (snap_num[3:0]   == 4'h0);
  assign zero[1] = (snap_num[7:4]   == 4'h0);
  assign zero[2] = (snap_num[11:8]  == 4'h0);
  assign zero[3] = (snap_num[15:12] == 4'h0);

  // Digit k blanks only when it and every more-significant digit are zero.
  assign blank[0] = 1'b0;
  assign blank[1] = snap_blz & zero[3] & zero[2] & zero[1];
  assign blank[2] = snap_blz & zero[3] & zero[2];
  assign blank[3] = snap_blz & zero[3];

  bcd_to_seg u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge value of every other register, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      idx        <= IDX_LAST;
      snap_num   <= '0;
      snap_dp    <= '0;
      snap_blz   <= 1'b0;
      active     <= 1'b0;
      an         <= 4'b1111;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;

      if (tick) begin
        presc  <= '0;
        active <= 1'b1;
        if (idx == IDX_LAST) begin
          idx        <= '0;
          snap_num   <= num;
          snap_dp    <= dp_in;
          snap_blz   <= blank_lz;
          frame_tick <= 1'b1;
        end else begin
          idx <= idx + 2'd1;
        end
      end else begin
        presc <= presc + 1'b1;
      end

      // Outputs trail idx/snapshot by one cycle and hold for the whole slot.
      if (!active) begin
        an  <= 4'b1111;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        an <= ~(4'b0001 << idx);
        if (blank[idx]) begin
          seg <= SEG_OFF;
          dp  <= 1'b1;
        end else begin
          seg <= dec_seg;
          dp  <= ~snap_dp[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=4 (16-cycle frames).
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] num;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  seven_seg_scanner #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .num        (num),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  // At most one anode may ever be driven low.
  always @(negedge clk) begin
    if (!$isunknown(an))
      assert (an inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})
        else $error("FAIL an_onehot: an=%b required one-hot-low or all high", an);
  end

  // Called on the falling edge right after reset was released.
  task automatic check_startup(input string name);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
        errors++;
        $display("FAIL %s_dark[%0d]: an=%h seg=%h dp=%b required an=F seg=7F dp=1",
                 name, c, an, seg, dp);
      end
      checks++;
      if (frame_tick !== (c == 4)) begin
        errors++;
        $display("FAIL %s_frame_tick[%0d]: got %b required %b", name, c, frame_tick, c == 4);
      end
    end
  endtask

  // Called on the falling edge where frame_tick is high; checks the 16 cycles
  // that follow. Optionally changes num after the check at cycle change_at.
  task automatic check_frame(input string name,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dp_low,
                             input int change_at, input logic [15:0] new_num);
    logic [6:0] es;
    logic [3:0] ea;
    for (int k = 0; k < 16; k++) begin
      int d;
      @(negedge clk);
      d = k / 4;
      case (d)
        0:       es = s0;
        1:       es = s1;
        2:       es = s2;
        default: es = s3;
      endcase
      ea = ~(4'b0001 << d);
      checks++;
      if (an !== ea || seg !== es || dp !== ~dp_low[d]) begin
        errors++;
        $display("FAIL %s[%0d]: an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 name, k, an, seg, dp, ea, es, ~dp_low[d]);
      end
      checks++;
      if (frame_tick !== (k == 15)) begin
        errors++;
        $display("FAIL %s_frame_tick[%0d]: got %b required %b", name, k, frame_tick, k == 15);
      end
      if (k == change_at) num = new_num;
    end
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 40);
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_frame: frame_tick=%b required 1 within 40 cycles", name, frame_tick);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    num      = 16'h1234;
    dp_in    = 4'b0000;
    blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: an=%h seg=%h dp=%b ft=%b required F 7F 1 0",
               an, seg, dp, frame_tick);
    end
    reset = 1'b0;
    check_startup("reset");
  endtask

  task automatic test_scan();
    check_frame("scan1", 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000, -1, 16'h0);
    check_frame("scan2", 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000, -1, 16'h0);
  endtask

  task automatic test_blanking();
    num      = 16'h0070;
    blank_lz = 1'b1;
    dp_in    = 4'b1100;  // blanked digits must suppress their decimal points
    wait_frame("blank70");
    check_frame("blank70", 7'h40, 7'h78, 7'h7F, 7'h7F, 4'b0000, -1, 16'h0);
    num   = 16'h0000;
    dp_in = 4'b0000;
    wait_frame("blank00");
    check_frame("blank00", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000, -1, 16'h0);
  endtask

  task automatic test_snapshot();
    num      = 16'h1234;
    blank_lz = 1'b0;
    dp_in    = 4'b0000;
    wait_frame("snap");
    check_frame("snap_old", 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000, 5, 16'h5678);
    check_frame("snap_new", 7'h00, 7'h78, 7'h02, 7'h12, 4'b0000, -1, 16'h0);
  endtask

  task automatic test_dash_dp();
    num   = 16'h00A0;
    dp_in = 4'b0010;
    wait_frame("dash");
    check_frame("dash", 7'h40, 7'h3F, 7'h40, 7'h40, 4'b0010, -1, 16'h0);
    num      = 16'hF90C;
    dp_in    = 4'b1001;
    blank_lz = 1'b1;  // inner zero under a nonzero digit stays lit
    wait_frame("mixed");
    check_frame("mixed", 7'h3F, 7'h40, 7'h10, 7'h3F, 4'b1001, -1, 16'h0);
  endtask

  task automatic test_mid_reset();
    wait_frame("midrst");
    repeat (9) @(negedge clk);
    checks++;
    if (an !== 4'hB) begin
      errors++;
      $display("FAIL midrst_digit2: an=%h required B", an);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midrst_dark: an=%h seg=%h dp=%b ft=%b required F 7F 1 0",
               an, seg, dp, frame_tick);
    end
    reset = 1'b0;
    check_startup("midrst");
    check_frame("midrst_scan", 7'h3F, 7'h40, 7'h10, 7'h3F, 4'b1001, -1, 16'h0);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_snapshot();
    test_dash_dp();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
